// File: rtl/attention_qkt_seq.sv
// Purpose : sequential Q = I*WQ, K = I*WK projection followed by S = Q*K^T scoring with optional causal mask.
// Latency : SEQ_LEN*D_HEAD*D_MODEL cycles of projection, then D_HEAD+1 cycles per unmasked score (2 per masked).
// Backpres: a score is held on s_* until s_valid&&s_ready; the engine stalls in EMIT meanwhile.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   start, causal       job request (accepted only when idle) and causal-mask select
//   I, WQ, WK           flat row-major input matrices, captured on accepted start
//   busy, done          job in flight / one-cycle end-of-job pulse
//   Q, K                flat projected matrices, updated element-wise during projection
//   s_valid/s_ready     score stream handshake
//   s_data/s_row/s_col  score value and its (row, column) position; s_last marks the final score
module attention_qkt_seq #(
   parameter int SEQ_LEN     = 4,
   parameter int D_MODEL     = 16,
   parameter int D_HEAD      = 16,
   parameter int DATA_W      = 8,
   parameter int QK_SHIFT    = 7,
   parameter int SCALE_SHIFT = 2,
   parameter int S_W         = 16
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                start,
   input  logic                                causal,
   input  logic [SEQ_LEN*D_MODEL*DATA_W-1:0]   I,
   input  logic [D_MODEL*D_HEAD*DATA_W-1:0]    WQ,
   input  logic [D_MODEL*D_HEAD*DATA_W-1:0]    WK,
   output logic                                busy,
   output logic                                done,
   output logic [SEQ_LEN*D_HEAD*DATA_W-1:0]    Q,
   output logic [SEQ_LEN*D_HEAD*DATA_W-1:0]    K,
   output logic                                s_valid,
   input  logic                                s_ready,
   output logic [S_W-1:0]                      s_data,
   output logic [$clog2(SEQ_LEN)-1:0]          s_row,
   output logic [$clog2(SEQ_LEN)-1:0]          s_col,
   output logic                                s_last
);

   localparam int RW   = $clog2(SEQ_LEN);
   localparam int HW   = $clog2(D_HEAD);
   localparam int MW   = $clog2(D_MODEL);
   localparam int PW   = 2*DATA_W;
   localparam int QA_W = PW + MW;
   localparam int SA_W = PW + HW;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_PROJ  = 3'd1;
   localparam logic [2:0] ST_SCORE = 3'd2;
   localparam logic [2:0] ST_EMIT  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic signed [QA_W-1:0] QK_MAX = QA_W'((1 << (DATA_W-1)) - 1);
   localparam logic signed [QA_W-1:0] QK_MIN = ~QK_MAX;
   localparam logic signed [SA_W-1:0] S_MAX  = SA_W'((1 << (S_W-1)) - 1);
   localparam logic signed [SA_W-1:0] S_MIN  = ~S_MAX;
   localparam logic [S_W-1:0]         S_MASK = {1'b1, {(S_W-1){1'b0}}};

   // Shift truncates toward -inf because the operand is signed.
   function automatic logic [DATA_W-1:0] sat_qk(input logic signed [QA_W-1:0] acc);
      logic signed [QA_W-1:0] sh;
      sh = acc >>> QK_SHIFT;
      if (sh > QK_MAX)      sh = QK_MAX;
      else if (sh < QK_MIN) sh = QK_MIN;
      return sh[DATA_W-1:0];
   endfunction

   function automatic logic [S_W-1:0] sat_s(input logic signed [SA_W-1:0] acc);
      logic signed [SA_W-1:0] sh;
      sh = acc >>> SCALE_SHIFT;
      if (sh > S_MAX)      sh = S_MAX;
      else if (sh < S_MIN) sh = S_MIN;
      return sh[S_W-1:0];
   endfunction

   // Captured job operands; only loaded on an accepted start, so no reset needed.
   logic [SEQ_LEN*D_MODEL*DATA_W-1:0] imat_q;
   logic [D_MODEL*D_HEAD*DATA_W-1:0]  wq_q, wk_q;

   logic [2:0]                       state_q, state_d;
   logic                             causal_q, causal_d;
   logic [RW-1:0]                    row_q, row_d;     // i in both phases
   logic [HW-1:0]                    hcol_q, hcol_d;   // j during projection
   logic [RW-1:0]                    scol_q, scol_d;   // j during scoring
   logic [MW-1:0]                    k_q, k_d;
   logic [HW-1:0]                    d_q, d_d;
   logic signed [QA_W-1:0]           accq_q, accq_d, acck_q, acck_d;
   logic signed [SA_W-1:0]           accs_q, accs_d;
   logic [SEQ_LEN*D_HEAD*DATA_W-1:0] qmat_q, qmat_d, kmat_q, kmat_d;
   logic                             s_valid_q, s_valid_d, s_last_q, s_last_d;
   logic [S_W-1:0]                   s_data_q, s_data_d;
   logic [RW-1:0]                    s_row_q, s_row_d, s_col_q, s_col_d;

   // Datapath: operand fetch and the three multiply-accumulate sums.
   int                     idx_i, idx_w, idx_qs, idx_ks, idx_o;
   logic signed [DATA_W-1:0] op_i, op_wq, op_wk, op_q, op_k;
   logic signed [PW-1:0]     p_q, p_k, p_s;
   logic signed [QA_W-1:0]   sum_q, sum_k;
   logic signed [SA_W-1:0]   sum_s;

   always_comb begin
      idx_i  = (int'(row_q)  * D_MODEL + int'(k_q))    * DATA_W;
      idx_w  = (int'(k_q)    * D_HEAD  + int'(hcol_q)) * DATA_W;
      idx_o  = (int'(row_q)  * D_HEAD  + int'(hcol_q)) * DATA_W;
      idx_qs = (int'(row_q)  * D_HEAD  + int'(d_q))    * DATA_W;
      idx_ks = (int'(scol_q) * D_HEAD  + int'(d_q))    * DATA_W;
      op_i   = imat_q[idx_i +: DATA_W];
      op_wq  = wq_q[idx_w +: DATA_W];
      op_wk  = wk_q[idx_w +: DATA_W];
      op_q   = qmat_q[idx_qs +: DATA_W];
      op_k   = kmat_q[idx_ks +: DATA_W];
      p_q    = PW'(op_i) * PW'(op_wq);
      p_k    = PW'(op_i) * PW'(op_wk);
      p_s    = PW'(op_q) * PW'(op_k);
      sum_q  = accq_q + QA_W'(p_q);
      sum_k  = acck_q + QA_W'(p_k);
      sum_s  = accs_q + SA_W'(p_s);
   end

   always_comb begin
      state_d   = state_q;
      causal_d  = causal_q;
      row_d     = row_q;
      hcol_d    = hcol_q;
      scol_d    = scol_q;
      k_d       = k_q;
      d_d       = d_q;
      accq_d    = accq_q;
      acck_d    = acck_q;
      accs_d    = accs_q;
      qmat_d    = qmat_q;
      kmat_d    = kmat_q;
      s_valid_d = s_valid_q;
      s_last_d  = s_last_q;
      s_data_d  = s_data_q;
      s_row_d   = s_row_q;
      s_col_d   = s_col_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               causal_d = causal;
               row_d    = '0;
               hcol_d   = '0;
               scol_d   = '0;
               k_d      = '0;
               d_d      = '0;
               accq_d   = '0;
               acck_d   = '0;
               accs_d   = '0;
               state_d  = ST_PROJ;
            end
         end

         ST_PROJ: begin
            if (k_q == MW'(D_MODEL-1)) begin
               qmat_d[idx_o +: DATA_W] = sat_qk(sum_q);
               kmat_d[idx_o +: DATA_W] = sat_qk(sum_k);
               accq_d = '0;
               acck_d = '0;
               k_d    = '0;
               if (hcol_q == HW'(D_HEAD-1)) begin
                  hcol_d = '0;
                  if (row_q == RW'(SEQ_LEN-1)) begin
                     row_d   = '0;
                     scol_d  = '0;
                     d_d     = '0;
                     accs_d  = '0;
                     state_d = ST_SCORE;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  hcol_d = hcol_q + 1'b1;
               end
            end else begin
               accq_d = sum_q;
               acck_d = sum_k;
               k_d    = k_q + 1'b1;
            end
         end

         ST_SCORE: begin
            if (causal_q && (scol_q > row_q)) begin
               // Masked position: no accumulation, present the most negative score.
               s_data_d  = S_MASK;
               s_valid_d = 1'b1;
               s_row_d   = row_q;
               s_col_d   = scol_q;
               s_last_d  = 1'b0;
               state_d   = ST_EMIT;
            end else if (d_q == HW'(D_HEAD-1)) begin
               s_data_d  = sat_s(sum_s);
               s_valid_d = 1'b1;
               s_row_d   = row_q;
               s_col_d   = scol_q;
               s_last_d  = (row_q == RW'(SEQ_LEN-1)) && (scol_q == RW'(SEQ_LEN-1));
               accs_d    = '0;
               d_d       = '0;
               state_d   = ST_EMIT;
            end else begin
               accs_d = sum_s;
               d_d    = d_q + 1'b1;
            end
         end

         ST_EMIT: begin
            if (s_ready) begin
               s_valid_d = 1'b0;
               s_last_d  = 1'b0;
               if (scol_q == RW'(SEQ_LEN-1)) begin
                  scol_d = '0;
                  if (row_q == RW'(SEQ_LEN-1)) begin
                     state_d = ST_DONE;
                  end else begin
                     row_d   = row_q + 1'b1;
                     state_d = ST_SCORE;
                  end
               end else begin
                  scol_d  = scol_q + 1'b1;
                  state_d = ST_SCORE;
               end
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (state_q == ST_IDLE && start) begin
         imat_q <= I;
         wq_q   <= WQ;
         wk_q   <= WK;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         causal_q  <= 1'b0;
         row_q     <= '0;
         hcol_q    <= '0;
         scol_q    <= '0;
         k_q       <= '0;
         d_q       <= '0;
         accq_q    <= '0;
         acck_q    <= '0;
         accs_q    <= '0;
         qmat_q    <= '0;
         kmat_q    <= '0;
         s_valid_q <= 1'b0;
         s_last_q  <= 1'b0;
         s_data_q  <= '0;
         s_row_q   <= '0;
         s_col_q   <= '0;
      end else begin
         state_q   <= state_d;
         causal_q  <= causal_d;
         row_q     <= row_d;
         hcol_q    <= hcol_d;
         scol_q    <= scol_d;
         k_q       <= k_d;
         d_q       <= d_d;
         accq_q    <= accq_d;
         acck_q    <= acck_d;
         accs_q    <= accs_d;
         qmat_q    <= qmat_d;
         kmat_q    <= kmat_d;
         s_valid_q <= s_valid_d;
         s_last_q  <= s_last_d;
         s_data_q  <= s_data_d;
         s_row_q   <= s_row_d;
         s_col_q   <= s_col_d;
      end
   end

   assign busy    = (state_q == ST_PROJ) || (state_q == ST_SCORE) || (state_q == ST_EMIT);
   assign done    = (state_q == ST_DONE);
   assign Q       = qmat_q;
   assign K       = kmat_q;
   assign s_valid = s_valid_q;
   assign s_last  = s_last_q;
   assign s_data  = s_data_q;
   assign s_row   = s_row_q;
   assign s_col   = s_col_q;

endmodule

// File: tb/tb_attention_qkt_seq.sv
// Purpose : directed self-checking bench for attention_qkt_seq.
// Latency : jobs take ~1041 cycles to the first score with default parameters.
// Backpres: the bench drives s_ready and can hold it low around score (1,2).
module tb_attention_qkt_seq;
   localparam int SL = 4, DM = 16, DH = 16, DW = 8, SW = 16;

   logic                  clk = 1'b0;
   logic                  reset_n, start, causal, s_ready;
   logic [SL*DM*DW-1:0]   I;
   logic [DM*DH*DW-1:0]   WQ, WK;
   logic                  busy, done, s_valid, s_last;
   logic [SL*DH*DW-1:0]   Q, K;
   logic [SW-1:0]         s_data;
   logic [1:0]            s_row, s_col;

   always #5 clk = ~clk;

   attention_qkt_seq dut (
      .clk(clk), .reset_n(reset_n), .start(start), .causal(causal),
      .I(I), .WQ(WQ), .WK(WK), .busy(busy), .done(done), .Q(Q), .K(K),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_row(s_row), .s_col(s_col), .s_last(s_last)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   // Results of the most recent collected job.
   int          hs_n, done_cyc, start_cyc, stall_n;
   bit          timed_out, busy_at_done, busy_after_start;
   logic [15:0] hs_dat [32];
   logic [1:0]  hs_row [32], hs_col [32];
   logic        hs_last [32];
   int          hs_cyc [32];
   logic [15:0] st_dat [8];
   logic [1:0]  st_row [8], st_col [8];

   logic [SL*DH*DW-1:0] exp_q, exp_k;

   task automatic start_job(input logic [7:0] iv, input logic [7:0] wqv,
                            input logic [7:0] wkv, input logic cz);
      @(posedge clk); #1;
      for (int n = 0; n < SL*DM; n++) I[n*DW +: DW] = iv;
      for (int n = 0; n < DM*DH; n++) begin
         WQ[n*DW +: DW] = wqv;
         WK[n*DW +: DW] = wkv;
      end
      causal    = cz;
      start     = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start  = 1'b0;
      causal = 1'b0;
      busy_after_start = busy;
   endtask

   // Records every handshake until done; holds s_ready low for stall_cycles while (1,2) is offered.
   task automatic collect(input int stall_cycles, input int budget);
      hs_n = 0; done_cyc = -1; timed_out = 1'b1; stall_n = 0; busy_at_done = 1'b1;
      s_ready = 1'b1;
      for (int c = 0; c < budget; c++) begin
         @(posedge clk); #1;
         if (done) begin
            done_cyc = cyc; busy_at_done = busy; timed_out = 1'b0;
            break;
         end
         if (s_valid && s_row == 2'd1 && s_col == 2'd2 && stall_n < stall_cycles) begin
            s_ready = 1'b0;
            st_dat[stall_n] = s_data; st_row[stall_n] = s_row; st_col[stall_n] = s_col;
            stall_n++;
         end else begin
            s_ready = 1'b1;
         end
         if (s_valid && s_ready) begin
            if (hs_n < 32) begin
               hs_dat[hs_n] = s_data; hs_row[hs_n] = s_row; hs_col[hs_n] = s_col;
               hs_last[hs_n] = s_last; hs_cyc[hs_n] = cyc;
            end
            hs_n++;
         end
      end
      s_ready = 1'b1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; start = 1'b0; causal = 1'b0; s_ready = 1'b1;
      I = '0; WQ = '0; WK = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, s_valid, s_last} !== 4'b0000)
         $display("FAIL reset_ctrl: busy/done/valid/last=%b required 0000", {busy, done, s_valid, s_last});
      checks++;
      if (s_data !== 16'h0 || s_row !== 2'd0 || s_col !== 2'd0)
         $display("FAIL reset_stream: data=%h row=%0d col=%0d required 0", s_data, s_row, s_col);
      checks++;
      if (Q !== '0 || K !== '0)
         $display("FAIL reset_qk: Q/K nonzero after reset required 0");
      errors += (({busy, done, s_valid, s_last} !== 4'b0000) ? 1 : 0)
              + ((s_data !== 16'h0 || s_row !== 2'd0 || s_col !== 2'd0) ? 1 : 0)
              + ((Q !== '0 || K !== '0) ? 1 : 0);
      reset_n = 1'b1;
   endtask

   task automatic test_nominal;
      start_job(8'h08, 8'h08, 8'h08, 1'b0);
      checks++;
      if (busy_after_start !== 1'b1) begin
         errors++; $display("FAIL nom_busy_rise: busy=%b required 1", busy_after_start);
      end
      collect(0, 3000);
      checks++;
      if (timed_out || hs_n != 16) begin
         errors++; $display("FAIL nom_count: handshakes=%0d timeout=%0d required 16 0", hs_n, timed_out);
      end
      exp_q = {(SL*DH){8'h08}};
      checks++;
      if (Q !== exp_q || K !== exp_q) begin
         errors++; $display("FAIL nom_qk: Q=%h K=%h required all 08", Q, K);
      end
      for (int n = 0; n < 16 && n < hs_n; n++) begin
         checks++;
         if ({hs_dat[n], hs_row[n], hs_col[n], hs_last[n]} !== {16'd256, 2'(n/4), 2'(n%4), (n == 15)}) begin
            errors++;
            $display("FAIL nom_score[%0d]: data=%0d row=%0d col=%0d last=%b required 256 %0d %0d %0d",
                     n, hs_dat[n], hs_row[n], hs_col[n], hs_last[n], n/4, n%4, (n == 15));
         end
      end
      checks++;
      if (hs_n >= 1 && hs_cyc[0] - start_cyc != 1041) begin
         errors++; $display("FAIL nom_first_latency: %0d cycles required 1041", hs_cyc[0] - start_cyc);
      end
      for (int n = 1; n < 16 && n < hs_n; n++) begin
         checks++;
         if (hs_cyc[n] - hs_cyc[n-1] != 17) begin
            errors++; $display("FAIL nom_spacing[%0d]: %0d required 17", n, hs_cyc[n] - hs_cyc[n-1]);
         end
      end
      checks++;
      if (hs_n < 16 || done_cyc != hs_cyc[15] + 1 || busy_at_done !== 1'b0) begin
         errors++; $display("FAIL nom_done: done_cyc=%0d busy=%b required %0d 0", done_cyc, busy_at_done,
                            (hs_n >= 16) ? hs_cyc[15] + 1 : -1);
      end
   endtask

   task automatic test_pos_sat;
      start_job(8'h7f, 8'h7f, 8'h7f, 1'b0);
      collect(0, 3000);
      checks++;
      if (timed_out || hs_n != 16) begin
         errors++; $display("FAIL pos_count: handshakes=%0d timeout=%0d required 16 0", hs_n, timed_out);
      end
      exp_q = {(SL*DH){8'h7f}};
      checks++;
      if (Q !== exp_q || K !== exp_q) begin
         errors++; $display("FAIL pos_qk: Q=%h K=%h required all 7f", Q, K);
      end
      for (int n = 0; n < 16 && n < hs_n; n++) begin
         checks++;
         if (hs_dat[n] !== 16'h7fff) begin
            errors++; $display("FAIL pos_score[%0d]: %h required 7fff", n, hs_dat[n]);
         end
      end
   endtask

   task automatic test_neg_sat;
      start_job(8'h80, 8'h7f, 8'h80, 1'b0);
      collect(0, 3000);
      checks++;
      if (timed_out || hs_n != 16) begin
         errors++; $display("FAIL neg_count: handshakes=%0d timeout=%0d required 16 0", hs_n, timed_out);
      end
      exp_q = {(SL*DH){8'h80}};
      exp_k = {(SL*DH){8'h7f}};
      checks++;
      if (Q !== exp_q || K !== exp_k) begin
         errors++; $display("FAIL neg_qk: Q=%h K=%h required all 80 / all 7f", Q, K);
      end
      for (int n = 0; n < 16 && n < hs_n; n++) begin
         checks++;
         if (hs_dat[n] !== 16'h8000) begin
            errors++; $display("FAIL neg_score[%0d]: %h required 8000", n, hs_dat[n]);
         end
      end
   endtask

   task automatic test_causal;
      logic [15:0] ev;
      start_job(8'h08, 8'h08, 8'h08, 1'b1);
      collect(0, 3000);
      checks++;
      if (timed_out || hs_n != 16) begin
         errors++; $display("FAIL causal_count: handshakes=%0d timeout=%0d required 16 0", hs_n, timed_out);
      end
      for (int n = 0; n < 16 && n < hs_n; n++) begin
         ev = ((n % 4) > (n / 4)) ? 16'h8000 : 16'd256;
         checks++;
         if ({hs_dat[n], hs_row[n], hs_col[n]} !== {ev, 2'(n/4), 2'(n%4)}) begin
            errors++;
            $display("FAIL causal_score[%0d]: data=%h row=%0d col=%0d required %h %0d %0d",
                     n, hs_dat[n], hs_row[n], hs_col[n], ev, n/4, n%4);
         end
      end
      for (int n = 1; n < 16 && n < hs_n; n++) begin
         checks++;
         if (hs_cyc[n] - hs_cyc[n-1] != (((n % 4) > (n / 4)) ? 2 : 17)) begin
            errors++; $display("FAIL causal_spacing[%0d]: %0d required %0d", n, hs_cyc[n] - hs_cyc[n-1],
                               ((n % 4) > (n / 4)) ? 2 : 17);
         end
      end
      checks++;
      if (hs_n < 16 || done_cyc != hs_cyc[15] + 1) begin
         errors++; $display("FAIL causal_done: done_cyc=%0d required one after last handshake", done_cyc);
      end
   endtask

   task automatic test_backpressure;
      start_job(8'h08, 8'h08, 8'h08, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      start = 1'b1; causal = 1'b1;      // must be ignored while busy
      @(posedge clk); #1;
      start = 1'b0; causal = 1'b0;
      collect(5, 3000);
      checks++;
      if (timed_out || hs_n != 16) begin
         errors++; $display("FAIL bp_count: handshakes=%0d timeout=%0d required 16 0", hs_n, timed_out);
      end
      checks++;
      if (stall_n != 5) begin
         errors++; $display("FAIL bp_stall_cycles: %0d required 5", stall_n);
      end
      for (int n = 0; n < 5 && n < stall_n; n++) begin
         checks++;
         if ({st_dat[n], st_row[n], st_col[n]} !== {16'd256, 2'd1, 2'd2}) begin
            errors++; $display("FAIL bp_hold[%0d]: data=%0d row=%0d col=%0d required 256 1 2",
                               n, st_dat[n], st_row[n], st_col[n]);
         end
      end
      for (int n = 0; n < 16 && n < hs_n; n++) begin
         checks++;
         if ({hs_dat[n], hs_row[n], hs_col[n]} !== {16'd256, 2'(n/4), 2'(n%4)}) begin
            errors++; $display("FAIL bp_score[%0d]: data=%0d row=%0d col=%0d required 256 %0d %0d",
                               n, hs_dat[n], hs_row[n], hs_col[n], n/4, n%4);
         end
      end
      checks++;
      if (hs_n >= 7 && hs_cyc[6] - hs_cyc[5] != 22) begin
         errors++; $display("FAIL bp_stall_timing: %0d required 22", hs_cyc[6] - hs_cyc[5]);
      end
   endtask

   task automatic test_mid_reset;
      int seen;
      start_job(8'h08, 8'h08, 8'h08, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      checks++;
      if ({busy, done, s_valid, s_last} !== 4'b0000 || s_data !== 16'h0 || s_row !== 2'd0 ||
          s_col !== 2'd0 || Q !== '0 || K !== '0) begin
         errors++; $display("FAIL midrst_outputs: busy=%b done=%b valid=%b data=%h Q/K zero=%b required all 0",
                            busy, done, s_valid, s_data, (Q == '0 && K == '0));
      end
      seen = 0;
      for (int c = 0; c < 1200; c++) begin
         @(posedge clk); #1;
         if (s_valid || done || busy) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL midrst_quiet: %0d active cycles required 0", seen);
      end
      start_job(8'h08, 8'h08, 8'h08, 1'b0);
      collect(0, 3000);
      checks++;
      if (timed_out || hs_n != 16) begin
         errors++; $display("FAIL midrst_count: handshakes=%0d timeout=%0d required 16 0", hs_n, timed_out);
      end
      exp_q = {(SL*DH){8'h08}};
      checks++;
      if (Q !== exp_q || K !== exp_q) begin
         errors++; $display("FAIL midrst_qk: Q=%h K=%h required all 08", Q, K);
      end
      for (int n = 0; n < 16 && n < hs_n; n++) begin
         checks++;
         if ({hs_dat[n], hs_row[n], hs_col[n], hs_last[n]} !== {16'd256, 2'(n/4), 2'(n%4), (n == 15)}) begin
            errors++; $display("FAIL midrst_score[%0d]: data=%0d row=%0d col=%0d required 256 %0d %0d",
                               n, hs_dat[n], hs_row[n], hs_col[n], n/4, n%4);
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_pos_sat();
      test_neg_sat();
      test_causal();
      test_backpressure();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
